// File: rtl/design_switch_controller.sv
// Hands the shared GPIO pads from one user design to another: filters the raw
// select request, then walks the pads through isolate -> reset hold -> run.
module design_switch_controller #(
    parameter int SYNC_STAGES    = 2,
    parameter int STABLE_CYCLES  = 4,
    parameter int ISOLATE_CYCLES = 8,
    parameter int RESET_CYCLES   = 16
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic [3:0]  design_select_req,
    output logic [3:0]  active_select,
    output logic [12:1] designs_cs,
    output logic [12:1] designs_n_rst,
    output logic        gpio_isolate,
    output logic        switch_busy
);

    localparam int MAX_CYC = (ISOLATE_CYCLES > RESET_CYCLES) ? ISOLATE_CYCLES : RESET_CYCLES;
    localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
    localparam int STB_W   = $clog2(STABLE_CYCLES + 1);

    localparam logic [CNT_W-1:0] ISO_LOAD = CNT_W'(ISOLATE_CYCLES - 1);
    localparam logic [CNT_W-1:0] RST_LOAD = CNT_W'(RESET_CYCLES - 1);
    localparam logic [STB_W-1:0] STB_MAX  = STB_W'(STABLE_CYCLES);
    localparam logic [STB_W-1:0] STB_ONE  = STB_W'(1);

    typedef enum logic [1:0] {
        ST_OFF,
        ST_ISOLATE,
        ST_RESET,
        ST_RUN
    } state_e;

    logic [3:0]       sync_q [SYNC_STAGES];
    logic [3:0]       sync_sel;
    logic [3:0]       prev_q;
    logic [STB_W-1:0] stb_q, stb_d;
    logic [3:0]       target_q, target_d;
    logic             target_valid;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] tmr_q, tmr_d;
    logic [3:0]       active_q, active_d;
    logic [12:1]      cs_q, cs_d;
    logic [12:1]      nrst_q, nrst_d;
    logic             iso_q, iso_d;
    logic             busy_q, busy_d;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= design_select_req;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    assign sync_sel = sync_q[SYNC_STAGES-1];

    // A request is accepted only after STABLE_CYCLES identical synchronized samples.
    always_comb begin
        if (sync_sel != prev_q)
            stb_d = STB_ONE;
        else if (stb_q == STB_MAX)
            stb_d = stb_q;
        else
            stb_d = stb_q + STB_ONE;

        target_d = target_q;
        if (stb_d == STB_MAX && sync_sel != target_q)
            target_d = sync_sel;
    end

    assign target_valid = (target_q >= 4'd1) && (target_q <= 4'd12);

    always_comb begin
        state_d  = state_q;
        tmr_d    = tmr_q;
        active_d = active_q;

        unique case (state_q)
            ST_OFF: begin
                active_d = 4'd0;
                if (target_valid) begin
                    state_d = ST_ISOLATE;
                    tmr_d   = ISO_LOAD;
                end
            end
            ST_ISOLATE: begin
                if (tmr_q == '0) begin
                    if (target_valid) begin
                        state_d  = ST_RESET;
                        active_d = target_q;
                        tmr_d    = RST_LOAD;
                    end else begin
                        state_d = ST_OFF;
                    end
                end else begin
                    tmr_d = tmr_q - CNT_W'(1);
                end
            end
            ST_RESET: begin
                // A new target aborts the reset hold and re-isolates from scratch.
                if (target_q != active_q) begin
                    state_d  = ST_ISOLATE;
                    tmr_d    = ISO_LOAD;
                    active_d = 4'd0;
                end else if (tmr_q == '0) begin
                    state_d = ST_RUN;
                end else begin
                    tmr_d = tmr_q - CNT_W'(1);
                end
            end
            ST_RUN: begin
                if (target_q != active_q) begin
                    state_d  = ST_ISOLATE;
                    tmr_d    = ISO_LOAD;
                    active_d = 4'd0;
                end
            end
            default: begin
                state_d  = ST_OFF;
                active_d = 4'd0;
            end
        endcase
    end

    // Outputs are decoded from the next state so they register on the same edge.
    always_comb begin
        cs_d   = '1;
        nrst_d = '0;
        iso_d  = 1'b1;
        busy_d = 1'b0;

        unique case (state_d)
            ST_ISOLATE: busy_d = 1'b1;
            ST_RESET: begin
                busy_d = 1'b1;
                for (int i = 1; i <= 12; i++)
                    if (active_d == 4'(i)) cs_d[i] = 1'b0;
            end
            ST_RUN: begin
                iso_d = 1'b0;
                for (int i = 1; i <= 12; i++)
                    if (active_d == 4'(i)) begin
                        cs_d[i]   = 1'b0;
                        nrst_d[i] = 1'b1;
                    end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            prev_q   <= '0;
            stb_q    <= '0;
            target_q <= '0;
            state_q  <= ST_OFF;
            tmr_q    <= '0;
            active_q <= '0;
            cs_q     <= '1;
            nrst_q   <= '0;
            iso_q    <= 1'b1;
            busy_q   <= 1'b0;
        end else begin
            prev_q   <= sync_sel;
            stb_q    <= stb_d;
            target_q <= target_d;
            state_q  <= state_d;
            tmr_q    <= tmr_d;
            active_q <= active_d;
            cs_q     <= cs_d;
            nrst_q   <= nrst_d;
            iso_q    <= iso_d;
            busy_q   <= busy_d;
        end
    end

    assign active_select = active_q;
    assign designs_cs    = cs_q;
    assign designs_n_rst = nrst_q;
    assign gpio_isolate  = iso_q;
    assign switch_busy   = busy_q;

endmodule

// File: tb/tb_design_switch_controller.sv
// Scoreboard bench for design_switch_controller: expected output snapshots are
// queued against absolute clock counts when a request is driven.
module tb_design_switch_controller;

    localparam int P_OFF = 0;
    localparam int P_ISO = 1;
    localparam int P_RST = 2;
    localparam int P_RUN = 3;

    logic        clk = 1'b0;
    logic        n_rst;
    logic [3:0]  req;
    logic [3:0]  active_select;
    logic [12:1] designs_cs;
    logic [12:1] designs_n_rst;
    logic        gpio_isolate;
    logic        switch_busy;

    typedef struct {
        int          cyc;
        string       tag;
        logic [3:0]  act;
        logic [12:1] cs;
        logic [12:1] nr;
        logic        iso;
        logic        busy;
    } exp_t;

    exp_t sb[$];
    int   n_chk = 0;
    int   n_err = 0;
    int   cyc   = 0;

    design_switch_controller dut (
        .clk               (clk),
        .n_rst             (n_rst),
        .design_select_req (req),
        .active_select     (active_select),
        .designs_cs        (designs_cs),
        .designs_n_rst     (designs_n_rst),
        .gpio_isolate      (gpio_isolate),
        .switch_busy       (switch_busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic exp_t mk(input int c, input string tag, input int ph, input int d);
        exp_t        e;
        logic [12:1] b;
        b = '0;
        for (int i = 1; i <= 12; i++)
            if (i == d) b[i] = 1'b1;
        e.cyc  = c;
        e.tag  = tag;
        e.act  = 4'd0;
        e.cs   = 12'hFFF;
        e.nr   = 12'h000;
        e.iso  = 1'b1;
        e.busy = 1'b0;
        case (ph)
            P_ISO: e.busy = 1'b1;
            P_RST: begin
                e.act  = 4'(d);
                e.cs   = ~b;
                e.busy = 1'b1;
            end
            P_RUN: begin
                e.act = 4'(d);
                e.cs  = ~b;
                e.nr  = b;
                e.iso = 1'b0;
            end
            default: ;
        endcase
        return e;
    endfunction

    // Timeline of a hand-over whose request changed just after edge t0.
    task automatic expect_switch(input int t0, input int oph, input int od, input int nd,
                                 input int upto, input string tag);
        if (upto >= 1)  sb.push_back(mk(t0 + 1,  {tag, "@+1"},  oph,   od));
        if (upto >= 6)  sb.push_back(mk(t0 + 6,  {tag, "@+6"},  oph,   od));
        if (upto >= 7)  sb.push_back(mk(t0 + 7,  {tag, "@+7"},  P_ISO, 0));
        if (upto >= 14) sb.push_back(mk(t0 + 14, {tag, "@+14"}, P_ISO, 0));
        if (upto >= 15) sb.push_back(mk(t0 + 15, {tag, "@+15"}, P_RST, nd));
        if (upto >= 30) sb.push_back(mk(t0 + 30, {tag, "@+30"}, P_RST, nd));
        if (upto >= 31) sb.push_back(mk(t0 + 31, {tag, "@+31"}, P_RUN, nd));
    endtask

    task automatic chk_reset(input string tag);
        check({tag, ".act"},  32'(active_select), 32'h0);
        check({tag, ".cs"},   32'(designs_cs),    32'hFFF);
        check({tag, ".nrst"}, 32'(designs_n_rst), 32'h000);
        check({tag, ".iso"},  32'(gpio_isolate),  32'h1);
        check({tag, ".busy"}, 32'(switch_busy),   32'h0);
    endtask

    task automatic set_req(input logic [3:0] v, output int t0);
        @(negedge clk);
        req = v;
        t0  = cyc;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    always @(negedge clk) begin
        int   z;
        exp_t e;
        if (n_rst) begin
            z = 0;
            for (int i = 1; i <= 12; i++)
                if (!designs_cs[i]) z++;
            check("inv.one_cs", 32'(z <= 1), 32'h1);
            check("inv.nrst_cs", 32'(designs_n_rst & designs_cs), 32'h0);
            check("inv.nrst_iso", 32'((|designs_n_rst) & gpio_isolate), 32'h0);
            check("inv.run_busy", 32'(!gpio_isolate && switch_busy), 32'h0);
            while (sb.size() > 0 && sb[0].cyc == cyc) begin
                e = sb.pop_front();
                check({e.tag, ".act"},  32'(active_select), 32'(e.act));
                check({e.tag, ".cs"},   32'(designs_cs),    32'(e.cs));
                check({e.tag, ".nrst"}, 32'(designs_n_rst), 32'(e.nr));
                check({e.tag, ".iso"},  32'(gpio_isolate),  32'(e.iso));
                check({e.tag, ".busy"}, 32'(switch_busy),   32'(e.busy));
            end
        end
    end

    initial begin
        int   t0, t1, t2;
        exp_t e;

        n_rst = 1'b1;
        req   = 4'd5;
        #1 n_rst = 1'b0;
        #1 chk_reset("por_async");
        wait_cycles(3);
        chk_reset("por_hold");

        // Power-up into design 5.
        @(negedge clk);
        n_rst = 1'b1;
        t0    = cyc;
        expect_switch(t0, P_OFF, 0, 5, 31, "pwr5");
        wait_cycles(33);

        // 5 -> 9 while running.
        set_req(4'd9, t0);
        expect_switch(t0, P_RUN, 5, 9, 31, "sw9");
        wait_cycles(33);

        // 9 -> 3, then glitch rejection.
        set_req(4'd3, t0);
        expect_switch(t0, P_RUN, 9, 3, 31, "sw3");
        wait_cycles(33);

        set_req(4'd7, t0);
        for (int k = 1; k <= 14; k++) sb.push_back(mk(t0 + k, "glitch3", P_RUN, 3));
        wait_cycles(3);
        req = 4'd3;
        wait_cycles(15);

        // A four-sample pulse is accepted; target is 3 again by the end of isolation.
        set_req(4'd7, t0);
        expect_switch(t0, P_RUN, 3, 3, 31, "pulse4");
        wait_cycles(4);
        req = 4'd3;
        wait_cycles(29);

        // Invalid select from design 12.
        set_req(4'd12, t0);
        expect_switch(t0, P_RUN, 3, 12, 31, "sw12");
        wait_cycles(33);

        set_req(4'd14, t0);
        sb.push_back(mk(t0 + 6,  "inv14@+6",  P_RUN, 12));
        sb.push_back(mk(t0 + 7,  "inv14@+7",  P_ISO, 0));
        sb.push_back(mk(t0 + 14, "inv14@+14", P_ISO, 0));
        sb.push_back(mk(t0 + 15, "inv14@+15", P_OFF, 0));
        sb.push_back(mk(t0 + 20, "inv14@+20", P_OFF, 0));
        wait_cycles(21);

        set_req(4'd0, t0);
        for (int k = 1; k <= 15; k += 7) sb.push_back(mk(t0 + k, "req0", P_OFF, 0));
        wait_cycles(16);

        // Abort during reset hold: 2 -> 6, then 4 while 6 is held in reset.
        set_req(4'd2, t0);
        expect_switch(t0, P_OFF, 0, 2, 31, "sw2");
        wait_cycles(33);

        set_req(4'd6, t1);
        expect_switch(t1, P_RUN, 2, 6, 18, "sw6");
        wait_cycles(17);
        set_req(4'd4, t2);
        expect_switch(t2, P_RST, 6, 4, 31, "abort4");
        wait_cycles(33);

        // Asynchronous reset while design 8 is in reset hold.
        set_req(4'd8, t0);
        expect_switch(t0, P_RUN, 4, 8, 20, "sw8");
        wait_cycles(20);
        e = mk(0, "pre", P_RST, 8);
        check("pre_rst.cs",   32'(designs_cs),  32'(e.cs));
        check("pre_rst.busy", 32'(switch_busy), 32'h1);
        #3 n_rst = 1'b0;
        #1 chk_reset("mid_async");
        wait_cycles(2);
        chk_reset("mid_hold");
        @(negedge clk);
        n_rst = 1'b1;
        t0    = cyc;
        expect_switch(t0, P_OFF, 0, 8, 31, "reseq8");
        wait_cycles(33);

        check("sb_empty", 32'(sb.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/design_switch_controller.md
Name: design_switch_controller

Overview:
- Sequences safe hand-over between the 12 user designs sharing the Caravel GPIO pads.
- Takes a raw, possibly asynchronous design-select request and filters it.
- Before any design drives the pads it goes through: pad isolation → per-design reset hold → run.
- Drives the active-low chip selects, the per-design resets and a pad-isolation flag that the top-level GPIO mux uses to force gpio_oeb to all-ones and gpio_out to zero.

Parameters:
- SYNC_STAGES, 2: flip-flop stages on the select request.
- STABLE_CYCLES, 4: consecutive equal synchronized samples required before a request is accepted.
- ISOLATE_CYCLES, 8: cycles pads stay isolated with every design deselected.
- RESET_CYCLES, 16: cycles the incoming design is chip-selected but still held in reset.

Ports:
- clk  input  1  system clock
- n_rst  input  1  asynchronous active-low reset
- design_select_req  input  4  requested design (1..12 valid; 0 and 13..15 mean none)
- active_select  output  4  design currently owning the pads (0 when none)
- designs_cs  output  12 [12:1]  active-low chip select per design
- designs_n_rst  output  12 [12:1]  active-low reset per design
- gpio_isolate  output  1  1 = top level forces all pads to input
- switch_busy  output  1  1 while in ISOLATE or RESET

Behaviour:
- Reset is asynchronous on n_rst low. While low and after release:
  - state = OFF, target = 0, active_select = 0
  - designs_cs = 12'hFFF, designs_n_rst = 12'h000
  - gpio_isolate = 1, switch_busy = 0
  - synchronizer and filter cleared to 0
- Synchronizer: design_select_req passes through SYNC_STAGES FFs. Result is sync_sel.
- Stability filter:
  - Counter resets to 1 whenever sync_sel differs from the previous sample; otherwise it increments, saturating at STABLE_CYCLES.
  - target <= sync_sel on the clock where the counter reaches STABLE_CYCLES and sync_sel != target.
  - Total latency from a req change to the target update is SYNC_STAGES+STABLE_CYCLES clocks (6 at default).
  - A request shorter than STABLE_CYCLES synchronized cycles never reaches target.
- target_valid = (target >= 1 && target <= 12).
- State OFF:
  - Outputs as at reset.
  - If target_valid, go to ISOLATE next clock.
- State ISOLATE:
  - active_select = 0, designs_cs = all 1, designs_n_rst = all 0, gpio_isolate = 1, switch_busy = 1.
  - Down-counter loads ISOLATE_CYCLES-1 on entry.
  - At count 0: if target_valid, latch active_select <= target and go to RESET; otherwise go to OFF.
  - Target changes during ISOLATE do not restart the count; the value sampled at count 0 is used.
- State RESET:
  - designs_cs[active_select] = 0, all others 1.
  - designs_n_rst = all 0, gpio_isolate = 1, switch_busy = 1.
  - Counter loads RESET_CYCLES-1 on entry.
  - At count 0, go to RUN.
  - If target != active_select at any clock, go to ISOLATE immediately (abort; counter reloads).
- State RUN:
  - designs_cs[active_select] = 0 and designs_n_rst[active_select] = 1; all other bits are 1 and 0 respectively.
  - gpio_isolate = 0, switch_busy = 0.
  - If target != active_select, go to ISOLATE next clock, dropping cs and n_rst of the old design in that same transition.
- Invariants:
  - At most one designs_cs bit is low at any time.
  - A designs_n_rst bit is high only when its cs bit is low and state == RUN.
  - gpio_isolate is 0 only in RUN.
- All outputs are registered; they change one clock after the state/counter condition that causes them.
- Counter width is $clog2(max(ISOLATE_CYCLES, RESET_CYCLES)). Parameters are required to be ≥ 1.

Test Plan:
- Reset and power-up: assert n_rst with req = 5, then release → OFF outputs hold until the target updates 6 clocks later. ISOLATE then lasts 8 clocks and RESET 16 clocks. designs_cs = 12'hFEF from RESET entry. designs_n_rst[5] rises at the first RUN clock, 31 clocks after the req change. gpio_isolate falls at the same time.
- Switch 5→9 while in RUN: cs[5] and n_rst[5] drop one clock after the target update. 8 isolate clocks follow, then cs[9] = 0 for 16 clocks with n_rst[9] = 0, then n_rst[9] = 1. No clock ever has two cs bits low.
- Glitch rejection: in RUN with design 3, pulse req to 7 for 3 clocks → target, active_select and all outputs unchanged. A 4-synchronized-cycle pulse is accepted.
- Invalid select: in RUN with design 12, set req = 14 → ISOLATE then OFF. Outputs become active_select = 0, designs_cs = 12'hFFF, gpio_isolate = 1, switch_busy = 0. Set req = 0: no change.
- Abort in RESET: move req 2→6, then change req to 4 while in RESET for design 6 → the clock after target = 4, state is ISOLATE and cs[6] = 1. The sequence completes with design 4 in RUN.
- Async reset mid-RESET: pull n_rst low on a non-clock edge → outputs reach reset values immediately without waiting for a clock edge. After release the controller re-sequences from OFF.
